// File: rtl/reg_dump_unit_pkg.sv
// Shared definitions for the register-file dump engine: state encoding,
// register-index width, the zero-register constant and a helper that
// keeps the walk from ever touching register 0.
package reg_dump_unit_pkg;

  localparam int IDX_W = 5;
  localparam logic [IDX_W-1:0] ZERO_REG = '0;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    SEND = 3'd2,
    CSUM = 3'd3,
    DONE = 3'd4
  } state_e;

  // Register 0 is hard-wired to zero in the core, so a misconfigured
  // first index below 1 is pulled up to 1.
  function automatic logic [IDX_W-1:0] clamp_first(input int first_reg);
    logic [IDX_W-1:0] res;
    if (first_reg < 1) res = IDX_W'(1);
    else               res = IDX_W'(first_reg);
    return res;
  endfunction

endpackage

// File: rtl/reg_dump_csum.sv
// XOR checksum accumulator for the dump stream. Only present when
// REG_DUMP_CHECKSUM_EN is defined; otherwise this file is empty.
`ifdef REG_DUMP_CHECKSUM_EN
module reg_dump_csum #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              update_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] csum_o
);

  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] acc_d;

  // Clear on a new dump, fold in each handshaken register beat.
  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (update_i) begin
      acc_d = acc_q ^ data_i;
    end
  end

  // Accumulator register, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign csum_o = acc_q;

endmodule
`endif

// File: rtl/reg_dump_unit.sv
// Register-file dump engine: on start, walks registers FIRST_REG..LAST_REG
// through a spare read port and emits one valid/ready beat per register.
// Build option REG_DUMP_CHECKSUM_EN appends an XOR checksum beat
// (index 0) carrying out_last instead of the final register beat.
module reg_dump_unit
  import reg_dump_unit_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int FIRST_REG = 1,
  parameter int LAST_REG  = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  rf_ra,
  input  logic [DATA_W-1:0] rf_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_index,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  localparam logic [IDX_W-1:0] FIRST_IDX = clamp_first(FIRST_REG);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LAST_REG);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [IDX_W-1:0]  index_q, index_d;

`ifdef REG_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum;
  logic              csum_clear;
  logic              csum_update;

  // A new dump restarts the checksum; only register beats contribute.
  assign csum_clear  = (state_q == IDLE) && start;
  assign csum_update = (state_q == SEND) && out_ready;

  reg_dump_csum #(
    .DATA_W (DATA_W)
  ) u_csum (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (csum_clear),
    .update_i (csum_update),
    .data_i   (data_q),
    .csum_o   (csum)
  );
`endif

  // Next-state and output decode; the captured beat is held until handshake.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    data_d    = data_q;
    index_d   = index_q;
    busy      = (state_q != IDLE);
    done      = 1'b0;
    rf_ra     = ZERO_REG;
    out_valid = 1'b0;
    out_index = index_q;
    out_data  = data_q;
    out_last  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = FIRST_IDX;
          state_d = READ;
        end
      end

      READ: begin
        rf_ra   = idx_q;
        data_d  = rf_rd;
        index_d = idx_q;
        state_d = SEND;
      end

      SEND: begin
        out_valid = 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
        out_last  = 1'b0;
`else
        out_last  = (idx_q >= LAST_IDX);
`endif
        if (out_ready) begin
          if (idx_q < LAST_IDX) begin
            idx_d   = idx_q + 5'd1;
            state_d = READ;
          end else begin
`ifdef REG_DUMP_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = DONE;
`endif
          end
        end
      end

`ifdef REG_DUMP_CHECKSUM_EN
      CSUM: begin
        out_valid = 1'b1;
        out_index = ZERO_REG;
        out_data  = csum;
        out_last  = 1'b1;
        if (out_ready) begin
          state_d = DONE;
        end
      end
`endif

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and captured-beat registers; reset aborts any dump immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      index_q <= index_d;
    end
  end

endmodule

// File: tb/tb_reg_dump_unit.sv
// Self-checking bench for reg_dump_unit: two instances (full range 1..31 and
// range 8..9), a register-file array, a scoreboard queue filled from a
// behavioural model at start time and a monitor that pops on handshakes.
module tb_reg_dump_unit;

`ifdef REG_DUMP_CHECKSUM_EN
  localparam int CSUM_ON = 1;
`else
  localparam int CSUM_ON = 0;
`endif

  typedef struct {
    int          dut;
    logic [4:0]  idx;
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        out_ready;
  logic        start_v   [2];
  logic        busy      [2];
  logic        done      [2];
  logic [4:0]  rf_ra     [2];
  logic [31:0] rf_rd     [2];
  logic        out_valid [2];
  logic [4:0]  out_index [2];
  logic [31:0] out_data  [2];
  logic        out_last  [2];
  logic [31:0] rf        [32];

  beat_t exp_q[$];
  int    checks = 0;
  int    passed = 0;
  int    cyc = 0;
  int    beats[2];
  int    dones[2];
  int    done_cyc[2];
  int    ready_mode = 0;

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      reg_dump_unit #(
        .DATA_W    (32),
        .FIRST_REG (gi == 0 ? 1 : 8),
        .LAST_REG  (gi == 0 ? 31 : 9)
      ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start_v[gi]),
        .busy      (busy[gi]),
        .done      (done[gi]),
        .rf_ra     (rf_ra[gi]),
        .rf_rd     (rf_rd[gi]),
        .out_valid (out_valid[gi]),
        .out_ready (out_ready),
        .out_index (out_index[gi]),
        .out_data  (out_data[gi]),
        .out_last  (out_last[gi])
      );
      assign rf_rd[gi] = rf[rf_ra[gi]];
    end
  endgenerate

  function automatic int first_of(input int d);
    return (d == 0) ? 1 : 8;
  endfunction

  function automatic int last_of(input int d);
    return (d == 0) ? 31 : 9;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference: the dump is the listed registers in order, then optionally their XOR.
  task automatic push_dump(input int d);
    beat_t       b;
    logic [31:0] x;
    x = '0;
    for (int r = first_of(d); r <= last_of(d); r++) begin
      b.dut = d; b.idx = 5'(r); b.data = rf[r];
      b.last = (r == last_of(d)) && (CSUM_ON == 0);
      exp_q.push_back(b);
      x ^= rf[r];
    end
    if (CSUM_ON != 0) begin
      b.dut = d; b.idx = 5'd0; b.data = x; b.last = 1'b1;
      exp_q.push_back(b);
    end
  endtask

  // Ready pattern: 0 = always high, 1 = 0,0,1 repeating, 2 = random.
  initial begin
    int phase;
    phase = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: begin out_ready = (phase == 2); phase = (phase + 1) % 3; end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: stall-hold checks, rf_ra idle check, scoreboard pop on handshake.
  initial begin
    bit          stalled [2];
    logic [4:0]  p_idx   [2];
    logic [31:0] p_data  [2];
    logic        p_last  [2];
    beat_t       e;
    for (int d = 0; d < 2; d++) begin
      stalled[d] = 0; beats[d] = 0; dones[d] = 0; done_cyc[d] = 0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!reset) begin
          stalled[d] = 0;
        end else begin
          if (stalled[d]) begin
            check("hold_valid", out_valid[d], 1);
            check("hold_index", out_index[d], p_idx[d]);
            check("hold_data", out_data[d], p_data[d]);
            check("hold_last", out_last[d], p_last[d]);
          end
          if (out_valid[d]) check("rf_ra_zero_when_valid", rf_ra[d], 0);
          if (out_valid[d] && out_ready) begin
            beats[d]++;
            if (exp_q.size() == 0) begin
              checks++;
              $display("FAIL unexpected_beat: dut %0d index %0d data %0h, expected no beat",
                       d, out_index[d], out_data[d]);
            end else begin
              e = exp_q.pop_front();
              check("beat_dut", d, e.dut);
              check("beat_index", out_index[d], e.idx);
              check("beat_data", out_data[d], e.data);
              check("beat_last", out_last[d], e.last);
              $display("beat dut=%0d idx=%0d data=%08h last=%0b", d, out_index[d], out_data[d], out_last[d]);
            end
          end
          stalled[d] = out_valid[d] && !out_ready;
          p_idx[d] = out_index[d]; p_data[d] = out_data[d]; p_last[d] = out_last[d];
          if (done[d]) begin
            dones[d]++;
            done_cyc[d] = cyc;
          end
        end
      end
    end
  end

  // One full dump on DUT d; dup_at > 0 re-pulses start after that many beats.
  task automatic run_dump(input int d, input int mode, input int dup_at, input bit check_lat);
    int start_cyc, base_beats, base_dones, n_exp, t;
    bit dup_done;
    ready_mode = mode;
    @(posedge clk); #1;
    push_dump(d);
    n_exp = exp_q.size();
    base_beats = beats[d];
    base_dones = dones[d];
    start_v[d] = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    check("busy_before_start", busy[d], 0);
    @(posedge clk); #1;
    start_v[d] = 1'b0;
    @(negedge clk);
    check("busy_after_start", busy[d], 1);
    t = 0;
    dup_done = 0;
    while (dones[d] == base_dones && t < 3000) begin
      @(posedge clk); #1;
      start_v[d] = 1'b0;
      if (!dup_done && dup_at > 0 && (beats[d] - base_beats) >= dup_at) begin
        start_v[d] = 1'b1;
        dup_done = 1;
      end
      t++;
    end
    start_v[d] = 1'b0;
    check("done_within_budget", (t < 3000), 1);
    @(negedge clk);
    check("busy_after_done", busy[d], 0);
    repeat (4) @(negedge clk);
    check("done_count", dones[d] - base_dones, 1);
    check("beat_count", beats[d] - base_beats, n_exp);
    check("scoreboard_empty", exp_q.size(), 0);
    if (check_lat)
      check("done_latency", done_cyc[d] - start_cyc, 2 * (last_of(d) - first_of(d) + 1) + 1 + CSUM_ON);
    $display("dump dut=%0d beats=%0d dones=%0d", d, beats[d] - base_beats, dones[d] - base_dones);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      check({tag, "_valid"}, out_valid[d], 0);
      check({tag, "_busy"}, busy[d], 0);
      check({tag, "_done"}, done[d], 0);
      check({tag, "_rf_ra"}, rf_ra[d], 0);
      check({tag, "_data"}, out_data[d], 0);
      check({tag, "_last"}, out_last[d], 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t, base;
    reset = 1'b0;
    start_v[0] = 1'b0;
    start_v[1] = 1'b0;
    for (int r = 0; r < 32; r++) rf[r] = 32'hcafebabe;
    rf[0] = 32'hdeadbeef;
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset_state");
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // Full dump, ready high, all registers cafebabe.
    run_dump(0, 0, 0, 1);

    // Backpressure 0,0,1 with register 5 = 5.
    for (int r = 1; r < 32; r++) rf[r] = $urandom;
    rf[5] = 32'h00000005;
    run_dump(0, 1, 0, 0);

    // Second start while busy at beat 10 is ignored.
    run_dump(0, 0, 10, 1);

    // Reset mid-dump at beat 7.
    ready_mode = 0;
    @(posedge clk); #1;
    push_dump(0);
    base = beats[0];
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    t = 0;
    while ((beats[0] - base) < 7 && t < 500) begin
      @(posedge clk);
      t++;
    end
    check("reach_beat7", ((beats[0] - base) >= 7), 1);
    #3;
    reset = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    exp_q.delete();
    repeat (2) @(negedge clk);
    check("busy_in_reset", busy[0], 0);
    @(posedge clk); #2;
    reset = 1'b1;
    @(negedge clk);
    check("idle_after_reset_busy", busy[0], 0);
    check("idle_after_reset_done", done[0], 0);
    check("idle_after_reset_valid", out_valid[0], 0);
    run_dump(0, 0, 0, 1);

    // Range instance 8..9.
    rf[8] = 32'h11111111;
    rf[9] = 32'h22222222;
    run_dump(1, 0, 0, 1);

    // Random data with random backpressure on both instances.
    for (int r = 0; r < 32; r++) rf[r] = $urandom;
    run_dump(0, 2, 0, 0);
    run_dump(1, 2, 0, 0);
    run_dump(0, 2, 5, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/reg_dump_unit.md
# reg_dump_unit

Sequential register-file dump engine for the single-cycle MIPS core. On a start pulse it walks general-purpose registers FIRST_REG..LAST_REG through a spare combinational read port of the register file. Each captured value is emitted as one beat on a valid/ready stream. An off-chip checker or on-chip trace sink consumes the stream, so register contents can be checked in hardware rather than by hierarchical peeking.

## Interface
- DATA_W, 32, register width
- FIRST_REG, 1, first register index dumped
- LAST_REG, 31, last register index dumped; requires FIRST_REG <= LAST_REG <= 31
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset)
- start  input  1  one-cycle request to begin a dump
- busy  output  1  high from the cycle after accepted start until done
- done  output  1  one-cycle pulse after the final beat handshakes
- rf_ra  output  5  register-file read address (spare read port)
- rf_rd  input  DATA_W  register-file read data, combinational from rf_ra
- out_valid  output  1  beat valid
- out_ready  input  1  sink ready
- out_index  output  5  register index of the beat (0 for checksum beat)
- out_data  output  DATA_W  register value (or checksum)
- out_last  output  1  marks final beat of the dump

## Operation
- States: IDLE, READ, SEND, CSUM (only with checksum), DONE.
- IDLE: busy=0. If start=1, load idx=FIRST_REG and go to READ. Otherwise stay.
- READ: drive rf_ra=idx. On the clock edge, capture out_data<=rf_rd and out_index<=idx, then go to SEND.
- SEND: out_valid=1. out_last=1 iff idx==LAST_REG and the checksum is compiled out.
  - Handshake is out_valid&&out_ready, sampled at the rising edge.
  - Without a handshake, out_data, out_index and out_last hold stable.
  - On handshake with idx<LAST_REG: idx<=idx+1, go to READ.
  - On handshake with idx==LAST_REG: go to CSUM if the checksum is enabled, otherwise DONE.
- CSUM: out_valid=1, out_index=0, out_data=running checksum, out_last=1. On handshake, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- start is ignored while busy=1. A start asserted in the DONE cycle is also ignored.
- rf_ra=0 in every state except READ.
- Register 0 is never dumped, even if FIRST_REG=0 is misconfigured; FIRST_REG below 1 is clamped to 1.
- idx is 5 bits wide and never wraps, because the LAST_REG compare terminates the walk.

## Timing
- All outputs reset to 0 and the state resets to IDLE asynchronously while reset=0. The checksum accumulator also resets to 0.
- Reset mid-dump aborts immediately. No done pulse follows, and the first post-reset cycle is IDLE.
- Latency from start to the first out_valid is 2 cycles: the IDLE→READ edge, then the READ→SEND edge.
- With out_ready held high, there is one beat every 2 cycles.
- A full dump of 31 registers with ready held high takes 62 cycles from start to the last handshake. done follows one cycle later; add 1 cycle for the checksum beat.
- busy rises in the cycle after start is sampled and falls in the cycle after done.
- The value captured is what the register file holds in the READ cycle. Core writes in later cycles are not reflected; the core is expected to be halted.

## Configuration
- REG_DUMP_CHECKSUM_EN defined:
  - A DATA_W-bit XOR accumulator is updated with out_data on every register-beat handshake.
  - One extra CSUM beat is appended with index 0; out_last moves to that beat.
  - The accumulator clears on start.
- REG_DUMP_CHECKSUM_EN undefined: no accumulator, no CSUM state, and out_last is on the LAST_REG beat.

## Structure
- Shared package holds the state encoding (IDLE=0, READ=1, SEND=2, CSUM=3, DONE=4, 3 bits), the register-index width (5), and the zero-register constant.
- No sub-module is required. Optionally, a reg_dump_csum accumulator sub-module holds the REG_DUMP_CHECKSUM_EN logic.

## Test plan
- Full dump with ready high:
  - Stimulus: all 31 registers preset to 32'hcafebabe, then a single start.
  - Response: 31 beats with index 1..31, all carrying cafebabe, out_last only on index 31.
  - done arrives 63 cycles after start.
- Backpressure:
  - Stimulus: out_ready toggled 0,0,1 repeating, with register 5 = 32'h00000005.
  - Response: index 5 data holds 00000005 stable across both stalled cycles.
  - Beat count is still 31 and no beat is duplicated.
- Start while busy:
  - Stimulus: a second start pulse at beat 10.
  - Response: it is ignored; exactly one done and 31 beats.
- Reset mid-dump:
  - Stimulus: reset=0 at beat 7.
  - Response: out_valid, busy, done, rf_ra and out_data read 0 immediately.
  - A new start afterwards begins again at index 1.
- Range parameters:
  - Stimulus: FIRST_REG=8, LAST_REG=9, registers 8/9 = 32'h11111111 and 32'h22222222.
  - Response: 2 beats, last on index 9.
  - With REG_DUMP_CHECKSUM_EN: 3 beats, the third carrying index 0, data 33333333 and out_last=1.
